// File: rtl/spi_pkg.sv
// Shared state encoding and default configuration for the SPI responder.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } spi_state_e;

  localparam int SPI_DATA_WIDTH  = 8;
  localparam int SPI_SYNC_STAGES = 2;
  localparam int SPI_FILL_WORD   = 0;

endpackage

// File: rtl/spi_slave_if.sv
// Pin and local-logic signal bundle for spi_slave; slave modport is the DUT side.
interface spi_slave_if
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH
);
  logic                  sclk;
  logic                  cs;
  logic                  mosi;
  logic                  miso;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic                  tx_underrun;

  modport slave (
    input  sclk, cs, mosi, tx_data, tx_valid,
    output miso, tx_ready, rx_data, rx_valid, busy, tx_underrun
  );

  modport master (
    output sclk, cs, mosi, tx_data, tx_valid,
    input  miso, tx_ready, rx_data, rx_valid, busy, tx_underrun
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with single-cycle rise/fall pulses derived from
// the last two synchronized samples.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   prev_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= {SYNC_STAGES{RESET_VAL}};
      prev_p1 <= RESET_VAL;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], d};
      prev_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign q    = sync_p0[SYNC_STAGES-1];
  assign rise =  q && !prev_p1;
  assign fall = !q &&  prev_p1;

endmodule

// File: rtl/spi_slave.sv
// Mode-0, LSB-first SPI responder with byte-level tx/rx handshakes.
// Optional sticky underrun flag enabled by defining SPI_SLAVE_UNDERRUN_EN.
module spi_slave
  import spi_pkg::*;
#(
  parameter int                    DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int                    SYNC_STAGES = SPI_SYNC_STAGES,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD   = DATA_WIDTH'(SPI_FILL_WORD)
) (
  input logic        clk,
  input logic        reset,
  spi_slave_if.slave bus
);

  localparam int                   CNT_W       = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]     LAST_BIT    = CNT_W'(DATA_WIDTH - 1);
  localparam int                   SETTLE_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [SETTLE_W-1:0]  SETTLE_DONE = SETTLE_W'(SYNC_STAGES + 1);

  spi_state_e state, state_nxt;

  logic sclk_rise, sclk_fall, sclk_s_unused;
  logic cs_rise, cs_fall, cs_s_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;
  logic cs_start;

  logic load_cs, load_burst, load, rx_step, tx_step, tx_capture;

  logic [SETTLE_W-1:0]   settle_cnt;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  word_done;
  logic                  miso_q;
  logic                  rx_valid_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  buf_full;
  logic [DATA_WIDTH-1:0] tx_buf;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_word;
  logic [DATA_WIDTH-1:0] load_word;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .reset(reset), .d(bus.sclk),
    .q(sclk_s_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .reset(reset), .d(bus.cs),
    .q(cs_s_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .reset(reset), .d(bus.mosi),
    .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // The cs chain is preset high, so a pin already low at reset release would
  // flush through as a fake fall; ignore falls until the chain has refilled.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle_cnt <= '0;
    end else if (settle_cnt != SETTLE_DONE) begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  assign cs_start = cs_fall && (settle_cnt == SETTLE_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load_cs    = 1'b0;
    load_burst = 1'b0;
    rx_step    = 1'b0;
    tx_step    = 1'b0;
    case (state)
      IDLE: begin
        if (cs_start) state_nxt = LOAD;
      end
      LOAD: begin
        load_cs   = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        rx_step    = sclk_rise;
        tx_step    = sclk_fall && !word_done;
        load_burst = sclk_fall &&  word_done;
      end
      default: state_nxt = IDLE;
    endcase
    // Deselect overrides any coincident sclk edge or pending load.
    if (cs_rise) begin
      state_nxt  = IDLE;
      load_cs    = 1'b0;
      load_burst = 1'b0;
      rx_step    = 1'b0;
      tx_step    = 1'b0;
    end
  end

  assign load       = load_cs || load_burst;
  assign tx_capture = bus.tx_valid && !buf_full;
  assign load_word  = buf_full ? tx_buf : FILL_WORD;
  assign rx_word    = {mosi_s, rx_shift[DATA_WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      miso_q     <= 1'b0;
      bit_cnt    <= '0;
      word_done  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      buf_full   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (cs_rise) begin
        miso_q    <= 1'b0;
        word_done <= 1'b0;
      end else if (load) begin
        miso_q    <= load_word[0];
        bit_cnt   <= '0;
        word_done <= 1'b0;
      end else if (tx_step) begin
        miso_q <= tx_shift[1];
      end
      if (rx_step) begin
        if (bit_cnt == LAST_BIT) begin
          rx_data_q  <= rx_word;
          rx_valid_q <= 1'b1;
          bit_cnt    <= '0;
          word_done  <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      // A capture can only happen while empty, so it never races a load of a full buffer.
      if (tx_capture) begin
        buf_full <= 1'b1;
      end else if (load) begin
        buf_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      tx_shift <= load_word;
    end else if (tx_step) begin
      tx_shift <= tx_shift >> 1;
    end
    if (rx_step) rx_shift <= rx_word;
    if (tx_capture) tx_buf <= bus.tx_data;
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic underrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_q <= 1'b0;
    end else if (load && !buf_full) begin
      underrun_q <= 1'b1;
    end else if (load_cs && buf_full) begin
      underrun_q <= 1'b0;
    end
  end

  assign bus.tx_underrun = underrun_q;
`else
  assign bus.tx_underrun = 1'b0;
`endif

  assign bus.miso     = miso_q;
  assign bus.tx_ready = !buf_full;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed frames plus randomized frames against a word-level model.
module tb_spi_slave;

  localparam int         W    = 8;
  localparam int         SYNC = 2;
  localparam int         HALF = 6;
  localparam logic [7:0] FILL = 8'h00;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_slave_if #(.DATA_WIDTH(W)) bus ();

  spi_slave #(.DATA_WIDTH(W), .SYNC_STAGES(SYNC), .FILL_WORD(FILL)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] mdl_buf[$];
  bit         mdl_und;
  logic [7:0] exp_rx[$];
  logic [7:0] got_rx[$];

  logic [7:0] f_mo[4];
  logic [7:0] f_tx[4];
  bit         f_buf[4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit und_exp();
`ifdef SPI_SLAVE_UNDERRUN_EN
    return mdl_und;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) got_rx.push_back(bus.rx_data);
  end

  // Word-level model of one tx load: buffered word if present, else fill.
  task automatic mdl_load(input bit is_cs, output logic [7:0] w);
    if (mdl_buf.size() != 0) begin
      w = mdl_buf.pop_front();
      if (is_cs) mdl_und = 1'b0;
    end else begin
      w = FILL;
      mdl_und = 1'b1;
    end
  endtask

  task automatic write_tx(input logic [7:0] w);
    int n = 0;
    @(negedge clk);
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    while (bus.tx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("tx_accept", 32'(n < 50), 32'd1);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    chk("tx_ready_full", 32'(bus.tx_ready), 32'd0);
    mdl_buf.push_back(w);
  endtask

  task automatic spi_word(input logic [7:0] mo, output logic [7:0] mi);
    for (int i = 0; i < 8; i++) begin
      bus.mosi = mo[i];
      repeat (HALF) @(negedge clk);
      mi[i] = bus.miso;
      bus.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic compare_rx(input string tag);
    chk({tag, "_rx_count"}, 32'(got_rx.size()), 32'(exp_rx.size()));
    while (got_rx.size() != 0 && exp_rx.size() != 0) begin
      chk({tag, "_rx_word"}, 32'(got_rx.pop_front()), 32'(exp_rx.pop_front()));
    end
    got_rx.delete();
    exp_rx.delete();
  endtask

  task automatic run_frame(input string tag, input int n);
    logic [7:0] mi;
    logic [7:0] cur;
    if (f_buf[0] && mdl_buf.size() == 0) write_tx(f_tx[0]);
    @(negedge clk);
    bus.cs = 1'b0;
    repeat (8) @(negedge clk);
    mdl_load(1'b1, cur);
    for (int w = 0; w < n; w++) begin
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_tx_ready"}, 32'(bus.tx_ready), 32'(mdl_buf.size() == 0));
      chk({tag, "_underrun"}, 32'(bus.tx_underrun), 32'(und_exp()));
      if (w + 1 < n && f_buf[w+1] && mdl_buf.size() == 0) write_tx(f_tx[w+1]);
      spi_word(f_mo[w], mi);
      chk({tag, "_miso_word"}, 32'(mi), 32'(cur));
      exp_rx.push_back(f_mo[w]);
      repeat (HALF) @(negedge clk);
      // Last falling edge of every word triggers the next load.
      mdl_load(1'b0, cur);
    end
    bus.cs = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    chk({tag, "_miso_end"}, 32'(bus.miso), 32'd0);
    chk({tag, "_underrun_end"}, 32'(bus.tx_underrun), 32'(und_exp()));
    if (n > 0) chk({tag, "_rx_held"}, 32'(bus.rx_data), 32'(f_mo[n-1]));
    compare_rx(tag);
  endtask

  task automatic abort_frame(input string tag, input int nbits);
    logic [7:0] cur;
    @(negedge clk);
    bus.cs = 1'b0;
    repeat (8) @(negedge clk);
    mdl_load(1'b1, cur);
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = 1'($urandom);
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    bus.cs = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_miso"}, 32'(bus.miso), 32'd0);
    compare_rx(tag);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_miso"}, 32'(bus.miso), 32'd0);
    chk({tag, "_tx_ready"}, 32'(bus.tx_ready), 32'd1);
    chk({tag, "_rx_data"}, 32'(bus.rx_data), 32'd0);
    chk({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_underrun"}, 32'(bus.tx_underrun), 32'd0);
  endtask

  task automatic set_frame(input logic [7:0] mo0, input logic [7:0] tx0, input bit b0,
                           input logic [7:0] mo1, input logic [7:0] tx1, input bit b1);
    f_mo[0] = mo0; f_tx[0] = tx0; f_buf[0] = b0;
    f_mo[1] = mo1; f_tx[1] = tx1; f_buf[1] = b1;
    f_mo[2] = 8'h00; f_tx[2] = 8'h00; f_buf[2] = 1'b0;
    f_mo[3] = 8'h00; f_tx[3] = 8'h00; f_buf[3] = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    bus.sclk     = 1'b0;
    bus.cs       = 1'b1;
    bus.mosi     = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    mdl_und      = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("por");
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check_reset_state("idle");

    set_frame(8'hE6, 8'h03, 1'b1, 8'h00, 8'h00, 1'b0);
    run_frame("exch", 1);
    set_frame(8'h0F, 8'hC3, 1'b1, 8'h00, 8'h00, 1'b0);
    run_frame("second", 1);
    set_frame(8'hA5, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    run_frame("empty", 1);

    abort_frame("abort", 3);
    set_frame(8'h5A, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    run_frame("post_abort", 1);

    set_frame(8'h9C, 8'h12, 1'b1, 8'h61, 8'h34, 1'b1);
    run_frame("burst", 2);

    // Reset in the middle of a frame with cs held low.
    write_tx(8'h77);
    @(negedge clk);
    bus.cs = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("mid_rst");
    reset = 1'b0;
    mdl_buf.delete();
    mdl_und = 1'b0;
    got_rx.delete();
    for (int i = 0; i < 10; i++) begin
      bus.mosi = 1'($urandom);
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    compare_rx("mid_rst");
    bus.cs = 1'b1;
    repeat (8) @(negedge clk);
    set_frame(8'h3C, 8'hB1, 1'b1, 8'h00, 8'h00, 1'b0);
    run_frame("after_rst", 1);

    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        abort_frame("rnd_abort", $urandom_range(1, 7));
      end else begin
        for (int j = 0; j < 4; j++) begin
          f_mo[j]  = 8'($urandom);
          f_tx[j]  = 8'($urandom);
          f_buf[j] = 1'($urandom);
        end
        run_frame("rnd", $urandom_range(1, 3));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder; the peripheral end of the link our spi master drives.
- Mode 0 (CPOL=0, CPHA=0), LSB first, one or more words per cs-low frame.
- Oversamples sclk/cs/mosi on the system clock and exposes byte-level tx/rx handshakes to local logic.
- Sits between the external SPI pins and a register file or FIFO.

Parameters:
- DATA_WIDTH, 8, bits per SPI word.
- SYNC_STAGES, 2, synchronizer flops on sclk, cs and mosi (minimum 2).
- FILL_WORD, 0, value shifted out when no tx word is buffered.

Ports:
- clk  input  1  system clock; must be at least 4x the sclk frequency.
- reset  input  1  synchronous, active-high reset.
- sclk  input  1  SPI clock from master.
- cs  input  1  chip select, active low.
- mosi  input  1  master-out data.
- miso  output  1  slave-out data.
- tx_data  input  DATA_WIDTH  next word to transmit.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  tx buffer empty; capture occurs when tx_valid && tx_ready.
- rx_data  output  DATA_WIDTH  last complete received word; held until the next word completes.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- busy  output  1  frame in progress.
- tx_underrun  output  1  sticky flag (see Optional Feature).

Behaviour:
- Reset: all synchronizers cleared, with cs sync preset to 1.
  - Outputs after reset: miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, tx_underrun=0.
  - Tx buffer empty, state IDLE.
- Input conditioning: sclk, cs and mosi each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last two synchronized samples.
  - All actions below occur on the clk edge after detection, which is SYNC_STAGES+1 clk after the pin edge.
- IDLE:
  - miso=0, busy=0.
  - cs fall -> LOAD.
- LOAD, one cycle:
  - tx_shift <= tx buffer if full, else FILL_WORD; buffer marked empty.
  - miso <= bit0 of the loaded word; bit_cnt=0; busy=1.
  - Go to SHIFT.
- SHIFT:
  - On sclk rise: rx_shift <= {mosi_s, rx_shift[W-1:1]}; bit_cnt++.
  - When bit_cnt reaches W-1 on a rise: rx_data <= assembled word, rx_valid=1 for one cycle, bit_cnt=0, word_done=1.
  - On sclk fall with word_done=0: tx_shift >>= 1, miso <= next bit.
  - On sclk fall with word_done=1: perform the LOAD action inline, which supports multi-word bursts. Clear word_done.
- cs rise in any state:
  - Go to IDLE next cycle; miso=0; busy=0.
  - Partial rx word discarded with no rx_valid.
  - A tx word already loaded into tx_shift is lost; a buffered word stays buffered.
- Tx handshake:
  - tx_ready = !buffer_full.
  - If a load and a tx_valid&&tx_ready capture happen in the same cycle and the buffer was empty, the load uses FILL_WORD and the new word is buffered.
- Simultaneous sclk edge and cs rise in the same cycle: cs rise wins, and the edge is ignored.
- Reset mid-frame: returns to IDLE immediately. The frame is ignored until cs goes high and then falls again.

Optional Feature:
- Macro SPI_SLAVE_UNDERRUN_EN.
- Defined: tx_underrun is set on any load that finds the tx buffer empty. It stays set until reset or until the next cs fall that loads from a full buffer.
- Undefined: tx_underrun is tied 0 and the detection logic is removed.

Decomposition:
- Package spi_pkg holds:
  - state enum (IDLE, LOAD, SHIFT)
  - default DATA_WIDTH and SYNC_STAGES constants
  - FILL_WORD default
- Sub-module spi_sync_edge: parameterized SYNC_STAGES synchronizer with rise/fall pulse outputs.
  - Instanced for sclk and cs; mosi uses it with the edge outputs unused.

Test Plan:
- Word exchange: tx buffered 0x03, master sends 0xE6 -> miso sequence 1,1,0,0,0,0,0,0 on sclk falls; rx_data=0xE6 with a single rx_valid pulse; tx_ready returns 1 after LOAD.
- Second frame: tx 0xC3, master sends 0x0F -> rx_data=0x0F; miso bits 1,1,0,0,0,0,1,1.
- Empty tx buffer, master sends 0xA5 -> slave shifts 0x00, rx_data=0xA5.
  - With SPI_SLAVE_UNDERRUN_EN: tx_underrun=1. Without it: tx_underrun=0.
- Abort: cs rises after 3 sclk cycles -> no rx_valid, busy=0 within SYNC_STAGES+2 clk, miso=0.
  - A following full frame sending 0x5A yields rx_data=0x5A.
- Burst: cs held low for 16 sclk, tx 0x12 then 0x34 written via handshake -> two rx_valid pulses; miso carries 0x12 then 0x34, LSB first.
- Reset asserted mid-frame -> all outputs at reset values next cycle.
  - Remaining sclk pulses while cs stays low produce no rx_valid.
  - A new frame after cs high then low works normally.
